// File: rtl/div_mon_pkg.sv
// Shared types and default constants for the divided-clock monitor.
package div_mon_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } mon_state_e;

  localparam int DEF_CNT_W      = 8;
  localparam int DEF_LOCK_COUNT = 4;
  localparam int DEF_TIMEOUT    = 255;
  localparam int MATCH_W        = 4;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with synchronous reset to 0.
// Also used for FIFO pointer bits.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/div_clk_monitor.sv
// Synchronises a divided clock into clk, emits edge strobes, measures its period and tracks lock.
// Define DIVMON_FALL_EN to build the falling-edge strobe; otherwise fall_stb is tied to 0.
module div_clk_monitor
  import div_mon_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             lost
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [MATCH_W-1:0] LOCK_V    = MATCH_W'(LOCK_COUNT);

  logic               s2;
  logic               s3_q, s3_d;
  logic               rise;
  mon_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ref_per_q, ref_per_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               first_q, first_d;
  logic               rise_stb_q, rise_stb_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               period_vld_q, period_vld_d;
  logic               locked_q, locked_d;
  logic               lost_q, lost_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (div_in),
    .q   (s2)
  );

  // A rise on the timeout cycle takes priority, so the period-equals-TIMEOUT case still measures.
  always_comb begin
    rise         = s2 & ~s3_q;
    s3_d         = s2;
    rise_stb_d   = rise;
    state_d      = state_q;
    ref_per_d    = ref_per_q;
    match_d      = match_q;
    first_d      = first_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    lost_d       = 1'b0;
    if (rise)                  cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    case (state_q)
      HUNT: begin
        if (rise) begin
          state_d = ACQ;
          first_d = 1'b1;
        end
      end
      ACQ: begin
        if (rise) begin
          period_d     = cnt_q;
          period_vld_d = 1'b1;
          if (first_q) begin
            ref_per_d = cnt_q;
            match_d   = '0;
            first_d   = 1'b0;
          end else if (cnt_q == ref_per_q) begin
            match_d = match_q + MATCH_W'(1);
            if (match_q + MATCH_W'(1) == LOCK_V) state_d = LOCK;
          end else begin
            ref_per_d = cnt_q;
            match_d   = '0;
          end
        end else if (cnt_q == TIMEOUT_V) begin
          state_d = HUNT;
          lost_d  = 1'b1;
        end
      end
      LOCK: begin
        if (rise) begin
          period_d     = cnt_q;
          period_vld_d = 1'b1;
          if (cnt_q != ref_per_q) begin
            ref_per_d = cnt_q;
            match_d   = '0;
            state_d   = ACQ;
          end
        end else if (cnt_q == TIMEOUT_V) begin
          state_d = HUNT;
          lost_d  = 1'b1;
        end
      end
      default: state_d = HUNT;
    endcase

    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      ref_per_q    <= '0;
      match_q      <= '0;
      first_q      <= 1'b0;
      rise_stb_q   <= 1'b0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      s3_q         <= s3_d;
      cnt_q        <= cnt_d;
      ref_per_q    <= ref_per_d;
      match_q      <= match_d;
      first_q      <= first_d;
      rise_stb_q   <= rise_stb_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      locked_q     <= locked_d;
      lost_q       <= lost_d;
    end
  end

`ifdef DIVMON_FALL_EN
  logic fall_stb_q, fall_stb_d;

  always_comb begin
    fall_stb_d = ~s2 & s3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) fall_stb_q <= 1'b0;
    else     fall_stb_q <= fall_stb_d;
  end

  assign fall_stb = fall_stb_q;
`else
  assign fall_stb = 1'b0;
`endif

  assign rise_stb   = rise_stb_q;
  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign locked     = locked_q;
  assign lost       = lost_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed self-checking bench for div_clk_monitor: main instance (CNT_W=8, TIMEOUT=20)
// plus a narrow instance (CNT_W=4, TIMEOUT=15) for the saturation boundary.
module tb_div_clk_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       div_in = 1'b0;
  logic       div_sat = 1'b0;
  logic       rise_stb, fall_stb, period_vld, locked, lost;
  logic [7:0] period;
  logic       rise_sat, fall_sat, vld_sat, locked_sat, lost_sat;
  logic [3:0] period_sat;

  int checks = 0;
  int passes = 0;

  int cyc = 0;
  int rise_cnt, vld_cnt, lost_cnt, last_period;
  int first_vld_rise, first_vld_period;
  int lock_rise, unlock_rise, unlock_period;
  int last_rise_cyc, lost_cyc;
  int sat_vld_cnt, sat_lost_cnt, sat_last_period;
  logic locked_prev = 1'b0;

  always #5 clk = ~clk;

  div_clk_monitor #(.CNT_W(8), .LOCK_COUNT(4), .TIMEOUT(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_in     (div_in),
    .rise_stb   (rise_stb),
    .fall_stb   (fall_stb),
    .period     (period),
    .period_vld (period_vld),
    .locked     (locked),
    .lost       (lost)
  );

  div_clk_monitor #(.CNT_W(4), .LOCK_COUNT(4), .TIMEOUT(15)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .div_in     (div_sat),
    .rise_stb   (rise_sat),
    .fall_stb   (fall_sat),
    .period     (period_sat),
    .period_vld (vld_sat),
    .locked     (locked_sat),
    .lost       (lost_sat)
  );

  task automatic checkOutput(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance one cycle, sample #1 after the edge and log output events.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rise_stb) begin
      rise_cnt++;
      last_rise_cyc = cyc;
    end
    if (period_vld) begin
      vld_cnt++;
      last_period = period;
      if (first_vld_rise == 0) begin
        first_vld_rise   = rise_cnt;
        first_vld_period = period;
      end
    end
    if (lost) begin
      lost_cnt++;
      lost_cyc = cyc;
    end
    if (locked && !locked_prev) lock_rise = rise_cnt;
    if (!locked && locked_prev) begin
      unlock_rise   = rise_cnt;
      unlock_period = period;
    end
    locked_prev = locked;
    if (vld_sat) begin
      sat_vld_cnt++;
      sat_last_period = period_sat;
    end
    if (lost_sat) sat_lost_cnt++;
  endtask

  task automatic clearStats();
    rise_cnt = 0; vld_cnt = 0; lost_cnt = 0; last_period = 0;
    first_vld_rise = 0; first_vld_period = 0;
    lock_rise = 0; unlock_rise = 0; unlock_period = 0;
    last_rise_cyc = 0; lost_cyc = 0;
    sat_vld_cnt = 0; sat_lost_cnt = 0; sat_last_period = 0;
    locked_prev = locked;
  endtask

  task automatic doReset();
    rst = 1'b1; div_in = 1'b0; div_sat = 1'b0;
    tick(); tick();
    rst = 1'b0;
    clearStats();
  endtask

  // n periods of hi cycles high then lo cycles low, on the main or the narrow instance.
  task automatic applyStimulus(input int hi, input int lo, input int n, input bit sat);
    for (int p = 0; p < n; p++) begin
      if (sat) div_sat = 1'b1; else div_in = 1'b1;
      repeat (hi) tick();
      if (sat) div_sat = 1'b0; else div_in = 1'b0;
      repeat (lo) tick();
    end
  endtask

  initial begin
    int v0, r0;
    int exp_rise[4];
    int exp_fall[4];
    exp_rise = '{0, 0, 1, 0};
`ifdef DIVMON_FALL_EN
    exp_fall = '{0, 0, 1, 0};
`else
    exp_fall = '{0, 0, 0, 0};
`endif
    clearStats();

    // Reset state
    tick(); tick();
    checkOutput("rst_rise_stb", rise_stb, 0);
    checkOutput("rst_fall_stb", fall_stb, 0);
    checkOutput("rst_period", period, 0);
    checkOutput("rst_period_vld", period_vld, 0);
    checkOutput("rst_locked", locked, 0);
    checkOutput("rst_lost", lost, 0);

    // Divide-by-2
    doReset();
    applyStimulus(1, 1, 10, 1'b0);
    checkOutput("div2_first_vld_rise", first_vld_rise, 2);
    checkOutput("div2_first_period", first_vld_period, 2);
    checkOutput("div2_lock_rise", lock_rise, 6);
    checkOutput("div2_lost", lost_cnt, 0);
    checkOutput("div2_locked", locked, 1);

    // Divide-by-4 to lock, then divide-by-6
    doReset();
    applyStimulus(2, 2, 8, 1'b0);
    checkOutput("div4_lock_rise", lock_rise, 6);
    checkOutput("div4_locked", locked, 1);
    checkOutput("div4_period", last_period, 4);
    applyStimulus(3, 3, 6, 1'b0);
    checkOutput("div6_unlock_rise", unlock_rise, 10);
    checkOutput("div6_unlock_period", unlock_period, 6);
    checkOutput("div6_lost", lost_cnt, 0);
    checkOutput("div6_relock_rise", lock_rise, 14);
    checkOutput("div6_locked", locked, 1);

    // Timeout after lock, then restart
    lost_cnt = 0;
    div_in = 1'b0;
    repeat (40) tick();
    checkOutput("to_lost_count", lost_cnt, 1);
    checkOutput("to_lost_gap", lost_cyc - last_rise_cyc, 20);
    checkOutput("to_locked", locked, 0);
    v0 = vld_cnt;
    r0 = rise_cnt;
    applyStimulus(3, 3, 1, 1'b0);
    checkOutput("restart_rises", rise_cnt - r0, 1);
    checkOutput("restart_no_vld", vld_cnt - v0, 0);
    checkOutput("restart_lost_count", lost_cnt, 1);

    // Edge latency
    doReset();
    repeat (3) tick();
    div_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("lat_rise_%0d", i), rise_stb, exp_rise[i]);
    end
    div_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("lat_fall_%0d", i), fall_stb, exp_fall[i]);
    end

    // Reset after three matches
    doReset();
    applyStimulus(2, 2, 5, 1'b0);
    checkOutput("mid_locked_pre", locked, 0);
    checkOutput("mid_vld_pre", vld_cnt, 4);
    checkOutput("mid_period_pre", period, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_rise_stb", rise_stb, 0);
    checkOutput("mid_rst_fall_stb", fall_stb, 0);
    checkOutput("mid_rst_period", period, 0);
    checkOutput("mid_rst_period_vld", period_vld, 0);
    checkOutput("mid_rst_locked", locked, 0);
    checkOutput("mid_rst_lost", lost, 0);
    clearStats();
    applyStimulus(2, 2, 5, 1'b0);
    checkOutput("mid_relock_not_yet", locked, 0);
    applyStimulus(2, 2, 1, 1'b0);
    checkOutput("mid_relock_rise", lock_rise, 6);
    checkOutput("mid_relock_locked", locked, 1);

    // Saturation boundary on the narrow instance
    doReset();
    applyStimulus(1, 14, 3, 1'b1);
    checkOutput("sat_p15_vld", sat_vld_cnt, 2);
    checkOutput("sat_p15_period", sat_last_period, 15);
    checkOutput("sat_p15_no_lost", sat_lost_cnt, 0);
    applyStimulus(1, 15, 2, 1'b1);
    checkOutput("sat_p16_lost", sat_lost_cnt, 1);
    checkOutput("sat_p16_vld", sat_vld_cnt, 3);
    checkOutput("sat_p16_period", sat_last_period, 15);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/div_clk_monitor.md
# div_clk_monitor

Fast-domain monitor for a divided clock. Takes a clock-derived square wave (e.g. the output of the divide-by-2 clock divider) as plain data, synchronises it into `clk`, and emits single-cycle edge strobes. It measures the period in `clk` cycles, declares lock after a run of identical periods, and flags loss of the divided clock on timeout. It sits on the consuming side of the divider and gives FIFO-side logic clean enables instead of a second clock.

## Interface
- `CNT_W`, 8: width of the period counter and the `period` output.
- `LOCK_COUNT`, 4: consecutive matching periods needed to assert `locked`; range 1..15.
- `TIMEOUT`, 255: `clk` cycles without a rising edge before loss is declared; must be ≤ 2^CNT_W−1 and ≥ 2.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `div_in`  in  1  divided-clock signal, asynchronous to or derived from `clk`.
- `rise_stb`  out  1  one-cycle pulse per synchronised rising edge of `div_in`.
- `fall_stb`  out  1  one-cycle pulse per synchronised falling edge.
- `period`  out  CNT_W  last measured rise-to-rise period in `clk` cycles.
- `period_vld`  out  1  one-cycle pulse when `period` updates.
- `locked`  out  1  level; high while in LOCK.
- `lost`  out  1  one-cycle pulse on timeout.

## Operation
- Input path: 2-FF synchroniser (`s1`, `s2`), then history flop `s3`. Rise = `s2 & ~s3`. Fall = `~s2 & s3`.
- Period counter `cnt`: loads 1 on a rise, otherwise increments and saturates at 2^CNT_W−1. On a rise, the measured period is the pre-load `cnt` value.
- FSM states are HUNT (reset state), ACQ and LOCK.
  - HUNT: on the first rise, go to ACQ and set `first=1`. Do not pulse `period_vld`.
  - ACQ: on each rise, update `period` and pulse `period_vld`.
    - If `first`, store `ref`, set `match=0`, clear `first`.
    - Else if the new period equals `ref`, increment `match`; when `match` reaches LOCK_COUNT, go to LOCK.
    - Else set `ref` to the new period and `match=0`.
  - LOCK: on each rise, update `period` and pulse `period_vld`. A mismatch sets `ref` to the new period, `match=0`, and returns to ACQ. `lost` does not fire.
- Timeout applies in ACQ and LOCK. When `cnt == TIMEOUT` and there is no rise this cycle, go to HUNT, pulse `lost`, and drop `locked`.
- Timeout and rise in the same cycle: the rise wins and no timeout occurs.
- In HUNT, `cnt` does not time out, and `lost` never pulses again until re-acquisition.
- `rst` mid-operation returns the block to HUNT in one cycle and discards all history, including the synchroniser.

## Timing
- Reset values: `rise_stb`, `fall_stb`, `period_vld`, `locked` and `lost` are 0. `period`, `cnt`, `ref` and `match` are 0. `s1`, `s2` and `s3` are 0.
- Latency: a `div_in` transition sampled at edge N shows on `rise_stb`/`fall_stb` after edge N+2 (three-flop depth).
- All outputs are registered. `period`, `period_vld`, `locked` and `lost` update on the same edge as the matching `rise_stb`.
- Minimum resolvable period is 2 `clk` cycles. A `div_in` toggling every cycle gives `period = 2`.
- `locked` rises on the same edge as the rise strobe that completes the LOCK_COUNT-th match.

## Configuration
- `DIVMON_FALL_EN` defined: fall detection is built and `fall_stb` pulses on synchronised falling edges.
- `DIVMON_FALL_EN` undefined: `fall_stb` is tied to 0 and the fall logic is absent. Rise, period and lock behaviour are identical in both builds.

## Structure
- Package `div_mon_pkg`:
  - state encoding (HUNT=0, ACQ=1, LOCK=2, 2-bit);
  - default CNT_W, LOCK_COUNT and TIMEOUT constants;
  - the width of `match`, fixed at 4 bits.
- Sub-module `sync_2ff`: single-bit 2-flop synchroniser with synchronous reset to 0. It is reused later for FIFO pointer bits.
- The top level holds the edge detect, counter, FSM and outputs.

## Test plan
- Divide-by-2 stimulus (`div_in` toggles every `clk`), LOCK_COUNT=4:
  - `period_vld` first pulses on the 2nd rise with `period=2`;
  - `locked` goes high on the 6th `rise_stb`;
  - `lost` stays 0.
- Divide-by-4 stimulus (2 high, 2 low), then switch to divide-by-6 after lock:
  - on the first 6-cycle period, `period=6` and `locked` drops to 0 with no `lost` pulse;
  - after 4 further matching periods, `locked` returns to 1.
- Stop toggling after lock with TIMEOUT=20:
  - `lost` pulses exactly once, 20 cycles after the last rise load, and `locked` goes to 0;
  - on restart, the first rise gives no `period_vld`.
- Edge latency: `div_in` 0→1 sampled at edge N gives `rise_stb` high only in the cycle after edge N+2. With `DIVMON_FALL_EN` defined, the following 1→0 gives `fall_stb` with the same latency; undefined, `fall_stb` stays 0.
- Reset mid-acquisition: assert `rst` for 1 cycle after 3 matches.
  - All outputs are 0 on the next cycle.
  - Lock then needs the full sequence again: 1 hunt rise, 1 reference rise and 4 matches.
- Saturation with CNT_W=4 and TIMEOUT=15: the period-15 boundary does not time out, because a rise on the `cnt==15` cycle wins and gives `period=15`; a period of 16 produces `lost`.
